// File: rtl/dice_roll_arbiter.sv
// Round-robin arbiter sharing one dice roller between NUM_REQ requesters.
// Optional range check on roller results enabled by DICE_RANGE_CHECK_EN.
module dice_roll_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SETTLE  = 2,
    parameter int ID_W    = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [5*NUM_REQ-1:0] sides_req,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 roll_valid,
    output logic [4:0]           roll_value,
    output logic [ID_W-1:0]      roll_id,
    output logic                 bad_sides,
    output logic                 busy,
    output logic [4:0]           roller_sides,
    input  logic [4:0]           roller_result,
    output logic                 range_err
);

    localparam logic [ID_W:0] NREQ = (ID_W+1)'(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      count;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] cur_id;
    logic [ID_W-1:0] win;
    logic [ID_W:0]   sum;
    logic            err_flag;
    logic            found;
    logic            win_legal;
    logic [4:0]      win_sides;
    logic [4:0]      sides_arr [NUM_REQ];

    function automatic logic legal(input logic [4:0] s);
        case (s)
            5'd4, 5'd6, 5'd8, 5'd10, 5'd12, 5'd20: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            sides_arr[i] = sides_req[5*i +: 5];
        end
    end

    // The requester just served is masked during its roll_valid cycle.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(i);
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            if (!found && req[sum[ID_W-1:0]] &&
                !(roll_valid && roll_id == sum[ID_W-1:0])) begin
                found = 1'b1;
                win   = sum[ID_W-1:0];
            end
        end
    end

    assign win_sides = sides_arr[win];
    assign win_legal = legal(win_sides);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_nxt = win_legal ? S_SETTLE : S_CAPTURE;
                end
            end
            S_SETTLE: begin
                if (count == 4'd0) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count        <= '0;
            ptr          <= '0;
            cur_id       <= '0;
            err_flag     <= 1'b0;
            gnt          <= '0;
            roller_sides <= '0;
            roll_valid   <= 1'b0;
            roll_value   <= '0;
            roll_id      <= '0;
            bad_sides    <= 1'b0;
        end else begin
            roll_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        cur_id <= win;
                        gnt    <= NUM_REQ'(1) << win;
                        if (win_legal) begin
                            roller_sides <= win_sides;
                            count        <= 4'(SETTLE - 1);
                            err_flag     <= 1'b0;
                        end else begin
                            err_flag <= 1'b1;
                        end
                    end
                end
                S_SETTLE: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end
                end
                S_CAPTURE: begin
                    roll_value   <= err_flag ? 5'd0 : roller_result;
                    bad_sides    <= err_flag;
                    roll_id      <= cur_id;
                    roll_valid   <= 1'b1;
                    gnt          <= '0;
                    roller_sides <= '0;
                    ptr          <= ({1'b0, cur_id} + 1'b1 >= NREQ) ?
                                    '0 : cur_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef DICE_RANGE_CHECK_EN
    logic [4:0] cur_sides;
    logic       range_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_sides <= '0;
            range_q   <= 1'b0;
        end else begin
            if (state == S_IDLE && found) begin
                cur_sides <= win_sides;
            end
            if (state == S_CAPTURE && !err_flag &&
                (roller_result == 5'd0 || roller_result > cur_sides)) begin
                range_q <= 1'b1;
            end
        end
    end

    assign range_err = range_q;
`else
    assign range_err = 1'b0;
`endif

endmodule
